// File: rtl/game_sprite_director_if.sv
// Bundle between game logic / sprite and the sprite director.
// The director is the slave; game logic (and the sprite's within flag) form the master side.
interface game_sprite_director_if #(
    parameter int X_WIDTH  = 10,
    parameter int Y_WIDTH  = 10,
    parameter int DX_WIDTH = 2,
    parameter int DY_WIDTH = 2
);
    logic                frame_start;
    // Handshake: launch is a level request, accepted only in IDLE; the accepting cycle shows
    // launch_ack=1 combinationally and launch_x/y/dx/dy are captured on that same clock edge.
    logic                launch;
    logic [X_WIDTH-1:0]  launch_x;
    logic [Y_WIDTH-1:0]  launch_y;
    logic [DX_WIDTH-1:0] launch_dx;
    logic [DY_WIDTH-1:0] launch_dy;
    logic                kill;
    logic                sprite_within_screen;

    logic                sprite_write_xy;
    logic                sprite_write_dxy;
    logic [X_WIDTH-1:0]  sprite_write_x;
    logic [Y_WIDTH-1:0]  sprite_write_y;
    logic [DX_WIDTH-1:0] sprite_write_dx;
    logic [DY_WIDTH-1:0] sprite_write_dy;
    logic                sprite_enable_update;
    logic                launch_ack;
    logic                sprite_active;
    logic                sprite_lost;
    logic [2:0]          state_dbg;

    modport master (
        output frame_start, launch, launch_x, launch_y, launch_dx, launch_dy, kill,
               sprite_within_screen,
        input  sprite_write_xy, sprite_write_dxy, sprite_write_x, sprite_write_y,
               sprite_write_dx, sprite_write_dy, sprite_enable_update, launch_ack,
               sprite_active, sprite_lost, state_dbg
    );

    modport slave (
        input  frame_start, launch, launch_x, launch_y, launch_dx, launch_dy, kill,
               sprite_within_screen,
        output sprite_write_xy, sprite_write_dxy, sprite_write_x, sprite_write_y,
               sprite_write_dx, sprite_write_dy, sprite_enable_update, launch_ack,
               sprite_active, sprite_lost, state_dbg
    );
endinterface

// File: rtl/game_sprite_director.sv
// Lifetime sequencer for one sprite: launch, load position/speed, frame-paced updates,
// off-screen / entry-timeout / kill detection and respawn cooldown.
module game_sprite_director #(
    parameter int X_WIDTH        = 10,
    parameter int Y_WIDTH        = 10,
    parameter int DX_WIDTH       = 2,
    parameter int DY_WIDTH       = 2,
    parameter int UPDATE_DIV     = 1,
    parameter int ENTRY_FRAMES   = 16,
    parameter int RESPAWN_FRAMES = 60,
    parameter int CNT_WIDTH      = 8
) (
    input logic                  clk,
    input logic                  reset,
    game_sprite_director_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD_XY  = 3'd1,
        S_LOAD_DXY = 3'd2,
        S_RUN      = 3'd3,
        S_COOLDOWN = 3'd4
    } state_t;

    localparam logic [CNT_WIDTH-1:0] DIV_LAST   = CNT_WIDTH'(UPDATE_DIV - 1);
    localparam logic [CNT_WIDTH-1:0] ENTRY_LAST = CNT_WIDTH'(ENTRY_FRAMES - 1);
    localparam logic [CNT_WIDTH-1:0] COOL_LAST  = CNT_WIDTH'(RESPAWN_FRAMES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX    = {CNT_WIDTH{1'b1}};

    state_t               state, state_nx;
    logic [CNT_WIDTH-1:0] div_cnt, div_nx;
    logic [CNT_WIDTH-1:0] entry_cnt, entry_nx;
    logic [CNT_WIDTH-1:0] cool_cnt, cool_nx;
    logic                 entered, entered_nx;
    logic                 update_q, update_nx;
    logic                 lost_q, lost_nx;
    logic                 accept;
    logic                 end_flight;

    logic [X_WIDTH-1:0]   wr_x;
    logic [Y_WIDTH-1:0]   wr_y;
    logic [DX_WIDTH-1:0]  wr_dx;
    logic [DY_WIDTH-1:0]  wr_dy;

    always_comb begin
        state_nx   = state;
        div_nx     = div_cnt;
        entry_nx   = entry_cnt;
        cool_nx    = cool_cnt;
        entered_nx = entered;
        update_nx  = 1'b0;
        lost_nx    = 1'b0;
        accept     = 1'b0;
        end_flight = 1'b0;

        case (state)
            S_IDLE: begin
                if (bus.launch) begin
                    accept   = 1'b1;
                    state_nx = S_LOAD_XY;
                end
            end
            S_LOAD_XY: begin
                if (bus.kill) end_flight = 1'b1;
                else          state_nx   = S_LOAD_DXY;
            end
            S_LOAD_DXY: begin
                if (bus.kill) begin
                    end_flight = 1'b1;
                end else begin
                    state_nx   = S_RUN;
                    div_nx     = '0;
                    entry_nx   = '0;
                    entered_nx = 1'b0;
                end
            end
            S_RUN: begin
                if (bus.kill) begin
                    end_flight = 1'b1;
                end else if (bus.frame_start) begin
                    // Lost either by leaving after entry, or by never showing up within the entry window.
                    if ((entered && !bus.sprite_within_screen) ||
                        (!entered && !bus.sprite_within_screen && entry_cnt == ENTRY_LAST)) begin
                        end_flight = 1'b1;
                    end else begin
                        if (bus.sprite_within_screen) entered_nx = 1'b1;
                        if (!entered && entry_cnt != CNT_MAX) entry_nx = entry_cnt + 1'b1;
                        if (div_cnt == DIV_LAST) begin
                            div_nx    = '0;
                            update_nx = 1'b1;
                        end else begin
                            div_nx = div_cnt + 1'b1;
                        end
                    end
                end
            end
            S_COOLDOWN: begin
                if (bus.frame_start) begin
                    if (cool_cnt == COOL_LAST) begin
                        cool_nx  = '0;
                        state_nx = S_IDLE;
                    end else begin
                        cool_nx = cool_cnt + 1'b1;
                    end
                end
            end
            default: state_nx = S_IDLE;
        endcase

        if (end_flight) begin
            lost_nx = 1'b1;
            cool_nx = '0;
            if (RESPAWN_FRAMES == 0) state_nx = S_IDLE;
            else                     state_nx = S_COOLDOWN;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            div_cnt   <= '0;
            entry_cnt <= '0;
            cool_cnt  <= '0;
            entered   <= 1'b0;
            update_q  <= 1'b0;
            lost_q    <= 1'b0;
            wr_x      <= '0;
            wr_y      <= '0;
            wr_dx     <= '0;
            wr_dy     <= '0;
        end else begin
            state     <= state_nx;
            div_cnt   <= div_nx;
            entry_cnt <= entry_nx;
            cool_cnt  <= cool_nx;
            entered   <= entered_nx;
            update_q  <= update_nx;
            lost_q    <= lost_nx;
            if (accept) begin
                wr_x  <= bus.launch_x;
                wr_y  <= bus.launch_y;
                wr_dx <= bus.launch_dx;
                wr_dy <= bus.launch_dy;
            end
        end
    end

    // update_q is only ever set while staying in RUN, so gating with kill alone keeps a kill cycle pulse-free.
    assign bus.launch_ack           = accept & reset;
    assign bus.sprite_write_xy      = (state == S_LOAD_XY) & ~bus.kill;
    assign bus.sprite_write_dxy     = (state == S_LOAD_DXY) & ~bus.kill;
    assign bus.sprite_enable_update = update_q & ~bus.kill;
    assign bus.sprite_lost          = lost_q;
    assign bus.sprite_active        = (state == S_LOAD_XY) | (state == S_LOAD_DXY) | (state == S_RUN);
    assign bus.sprite_write_x       = wr_x;
    assign bus.sprite_write_y       = wr_y;
    assign bus.sprite_write_dx      = wr_dx;
    assign bus.sprite_write_dy      = wr_dy;
    assign bus.state_dbg            = state;
endmodule

// File: tb/tb_game_sprite_director.sv
// Bench for game_sprite_director: directed flights plus randomized traffic against a frame-level model.
module tb_game_sprite_director;
    localparam int X_W = 10, Y_W = 10, DX_W = 2, DY_W = 2;
    localparam int DIV = 3, ENTRY = 16, RESP = 60, CW = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    game_sprite_director_if #(.X_WIDTH(X_W), .Y_WIDTH(Y_W), .DX_WIDTH(DX_W), .DY_WIDTH(DY_W)) bus();

    game_sprite_director #(
        .X_WIDTH(X_W), .Y_WIDTH(Y_W), .DX_WIDTH(DX_W), .DY_WIDTH(DY_W),
        .UPDATE_DIV(DIV), .ENTRY_FRAMES(ENTRY), .RESPAWN_FRAMES(RESP), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    // driver-owned
    int tag = 0;
    int timeouts = 0;
    bit do_final = 1'b0;

    // compare-process-owned
    int checks = 0, failures = 0, cyc = 0;
    int upd_cnt[16] = '{default: 0};
    int lost_cnt[16] = '{default: 0};
    int ack_cnt[16] = '{default: 0};
    int wxy_cnt[16] = '{default: 0};
    int wdxy_cnt[16] = '{default: 0};
    int t_ack = -1, t_wxy = -1, t_wdxy = -1;
    logic [31:0] x_at = 0, y_at = 0, dx_at = 0, dy_at = 0;
    bit l3 = 0, a3 = 0, r4 = 0, l4 = 0;
    int fs3 = 0, fs4 = 0;

    // model state: phase 0 idle, 1 load xy, 2 load dxy, 3 run, 4 cooldown
    int m_phase = 0, m_k = 0, m_c = 0;
    bit m_in = 0, m_upd = 0, m_lost = 0, n_upd, n_lost;
    logic [X_W-1:0] m_x = '0;
    logic [Y_W-1:0] m_y = '0;
    logic [DX_W-1:0] m_dx = '0;
    logic [DY_W-1:0] m_dy = '0;
    bit e_ack, e_wxy, e_wdxy, e_upd, e_act, fin;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (do_final) begin
            chk("xy_after_ack", 32'(t_wxy - t_ack), 32'd1);
            chk("dxy_after_ack", 32'(t_wdxy - t_ack), 32'd2);
            chk("held_x", x_at, 32'd100);
            chk("held_y", y_at, 32'd50);
            chk("held_dx", dx_at, 32'd1);
            chk("held_dy", dy_at, 32'd2);
            chk("updates_9_frames", 32'(upd_cnt[1]), 32'd3);
            chk("cooldown_frames", 32'(fs3), 32'd60);
            chk("ack_after_cooldown", 32'(ack_cnt[3]), 32'd1);
            chk("entry_timeout_frame", 32'(fs4), 32'd16);
            chk("entry_timeout_lost", 32'(lost_cnt[4]), 32'd1);
            chk("updates_before_timeout", 32'(upd_cnt[4]), 32'd5);
            chk("kill_no_update", 32'(upd_cnt[5]), 32'd0);
            chk("kill_lost", 32'(lost_cnt[5]), 32'd1);
            chk("kill_idle_no_lost", 32'(lost_cnt[6]), 32'd0);
            chk("reset_no_lost", 32'(lost_cnt[7]), 32'd0);
            chk("relaunch_ack", 32'(ack_cnt[8]), 32'd1);
            chk("relaunch_xy", 32'(wxy_cnt[8]), 32'd1);
            chk("relaunch_dxy", 32'(wdxy_cnt[8]), 32'd1);
            chk("timeouts", 32'(timeouts), 32'd0);
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end else if (!reset) begin
            chk("reset_outputs", {bus.launch_ack, bus.sprite_write_xy, bus.sprite_write_dxy,
                bus.sprite_enable_update, bus.sprite_lost, bus.sprite_active,
                bus.sprite_write_x, bus.sprite_write_y, bus.sprite_write_dx, bus.sprite_write_dy}, 32'd0);
            m_phase = 0; m_k = 0; m_c = 0; m_in = 0; m_upd = 0; m_lost = 0;
            m_x = '0; m_y = '0; m_dx = '0; m_dy = '0;
        end else begin
            e_ack  = (m_phase == 0) && bus.launch;
            e_wxy  = (m_phase == 1) && !bus.kill;
            e_wdxy = (m_phase == 2) && !bus.kill;
            e_upd  = m_upd && !bus.kill;
            e_act  = (m_phase >= 1) && (m_phase <= 3);
            chk("launch_ack", 32'(bus.launch_ack), 32'(e_ack));
            chk("write_xy", 32'(bus.sprite_write_xy), 32'(e_wxy));
            chk("write_dxy", 32'(bus.sprite_write_dxy), 32'(e_wdxy));
            chk("enable_update", 32'(bus.sprite_enable_update), 32'(e_upd));
            chk("sprite_lost", 32'(bus.sprite_lost), 32'(m_lost));
            chk("sprite_active", 32'(bus.sprite_active), 32'(e_act));
            chk("write_x", 32'(bus.sprite_write_x), 32'(m_x));
            chk("write_y", 32'(bus.sprite_write_y), 32'(m_y));
            chk("write_dx", 32'(bus.sprite_write_dx), 32'(m_dx));
            chk("write_dy", 32'(bus.sprite_write_dy), 32'(m_dy));

            // event log for the directed scenarios
            upd_cnt[tag]  += int'(bus.sprite_enable_update);
            lost_cnt[tag] += int'(bus.sprite_lost);
            ack_cnt[tag]  += int'(bus.launch_ack);
            wxy_cnt[tag]  += int'(bus.sprite_write_xy);
            wdxy_cnt[tag] += int'(bus.sprite_write_dxy);
            if (tag == 1) begin
                if (bus.launch_ack && t_ack < 0) t_ack = cyc;
                if (bus.sprite_write_xy && t_wxy < 0) t_wxy = cyc;
                if (bus.sprite_write_dxy && t_wdxy < 0) begin
                    t_wdxy = cyc;
                    x_at = 32'(bus.sprite_write_x);
                    y_at = 32'(bus.sprite_write_y);
                    dx_at = 32'(bus.sprite_write_dx);
                    dy_at = 32'(bus.sprite_write_dy);
                end
            end
            if (tag == 3) begin
                if (bus.sprite_lost) l3 = 1;
                if (bus.launch_ack) a3 = 1;
                if (l3 && !a3 && bus.frame_start) fs3++;
            end
            if (tag == 4) begin
                if (bus.sprite_lost) l4 = 1;
                if (r4 && !l4 && bus.frame_start) fs4++;
                if (bus.sprite_write_dxy) r4 = 1;
            end

            // advance the model to the next cycle
            n_upd = 0; n_lost = 0; fin = 0;
            if (m_phase == 0) begin
                if (bus.launch) begin
                    m_x = bus.launch_x; m_y = bus.launch_y;
                    m_dx = bus.launch_dx; m_dy = bus.launch_dy;
                    m_phase = 1;
                end
            end else if (m_phase >= 1 && m_phase <= 3 && bus.kill) begin
                fin = 1;
            end else if (m_phase == 1) begin
                m_phase = 2;
            end else if (m_phase == 2) begin
                m_phase = 3; m_k = 0; m_in = 0;
            end else if (m_phase == 3 && bus.frame_start) begin
                m_k++;
                if ((m_in && !bus.sprite_within_screen) ||
                    (!m_in && !bus.sprite_within_screen && m_k >= ENTRY)) begin
                    fin = 1;
                end else begin
                    if (bus.sprite_within_screen) m_in = 1;
                    if (m_k % DIV == 0) n_upd = 1;
                end
            end else if (m_phase == 4 && bus.frame_start) begin
                m_c++;
                if (m_c >= RESP) m_phase = 0;
            end
            if (fin) begin
                n_lost = 1; m_c = 0;
                m_phase = (RESP == 0) ? 0 : 4;
            end
            m_upd = n_upd; m_lost = n_lost;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic frame();
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
    endtask

    task automatic rand_launch_data();
        bus.launch_x  = X_W'($urandom);
        bus.launch_y  = Y_W'($urandom);
        bus.launch_dx = DX_W'($urandom);
        bus.launch_dy = DY_W'($urandom);
    endtask

    // Runs cycles with frame_start every gap cycles until launch_ack is seen, then steps past it.
    task automatic cycles_until_ack(input int max_cycles, input int gap);
        bit ok = 0;
        for (int c = 0; c < max_cycles; c++) begin
            bus.frame_start = (c % gap == 0);
            #1;
            if (bus.launch_ack) begin
                ok = 1;
                bus.frame_start = 1'b0;
            end
            @(posedge clk);
            #1;
            bus.frame_start = 1'b0;
            if (ok) break;
        end
        if (!ok) timeouts++;
    endtask

    initial begin
        bus.frame_start = 0; bus.launch = 0; bus.kill = 0; bus.sprite_within_screen = 0;
        bus.launch_x = '0; bus.launch_y = '0; bus.launch_dx = '0; bus.launch_dy = '0;
        idle(3);
        reset = 1'b1;
        idle(2);

        // launch and paced updates
        tag = 1;
        bus.launch_x = 10'd100; bus.launch_y = 10'd50; bus.launch_dx = 2'd1; bus.launch_dy = 2'd2;
        bus.launch = 1; bus.sprite_within_screen = 1;
        cycles_until_ack(10, 1000);
        bus.launch = 0;
        idle(2);
        repeat (9) begin frame(); idle(2); end
        idle(2);

        // leave the screen, then cooldown with launch held
        tag = 3;
        bus.sprite_within_screen = 0;
        frame();
        idle(1);
        rand_launch_data();
        bus.launch = 1;
        cycles_until_ack(400, 3);
        bus.launch = 0;

        // never enters: entry timeout
        tag = 4;
        repeat (20) begin frame(); idle(1); end
        tag = 11;
        rand_launch_data();
        bus.launch = 1;
        cycles_until_ack(400, 3);
        bus.launch = 0;

        // kill together with frame_start in RUN
        tag = 5;
        bus.sprite_within_screen = 1;
        idle(2);
        frame(); idle(1);
        frame(); idle(1);
        bus.kill = 1; bus.frame_start = 1;
        tick();
        bus.kill = 0; bus.frame_start = 0;
        idle(3);
        tag = 9;
        repeat (65) begin frame(); idle(1); end

        // kill while idle
        tag = 6;
        bus.kill = 1;
        idle(4);
        bus.kill = 0;

        // asynchronous reset during LOAD_DXY
        tag = 7;
        rand_launch_data();
        bus.launch = 1;
        cycles_until_ack(10, 1000);
        bus.launch = 0;
        tick();
        reset = 1'b0;
        idle(3);
        reset = 1'b1;
        tick();
        tag = 8;
        rand_launch_data();
        bus.launch = 1;
        cycles_until_ack(10, 1000);
        bus.launch = 0;
        idle(4);

        // randomized traffic
        tag = 10;
        for (int i = 0; i < 3000; i++) begin
            bus.frame_start = ($urandom_range(0, 2) == 0);
            bus.launch = ($urandom_range(0, 3) == 0);
            rand_launch_data();
            bus.kill = ($urandom_range(0, 40) == 0);
            if ($urandom_range(0, 7) == 0) bus.sprite_within_screen = ~bus.sprite_within_screen;
            if (i == 1500) reset = 1'b0;
            if (i == 1503) reset = 1'b1;
            tick();
        end
        bus.frame_start = 0; bus.launch = 0; bus.kill = 0;
        idle(2);
        do_final = 1'b1;
        idle(5);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule
